// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the 5-stage MIPS pipeline.
// Holds one instruction, issues a single data-bus transaction for memory ops,
// builds store strobes/data, extracts/merges load data and raises AdEL/AdES.
module mem_access_unit #(
    parameter int ADDR_W       = 32,
    parameter bit UNALIGNED_EN = 1'b1,
    parameter bit ALIGN_CHECK  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_rt,
    input  logic [31:0]       in_val,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [4:0]        in_dst,
    input  logic              in_wen,
    input  logic [5:0]        in_exc,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [3:0]        dreq_strobe,
    output logic [31:0]       dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [31:0]       dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [4:0]        out_dst,
    output logic              out_wen,
    output logic [31:0]       out_val,
    output logic [5:0]        out_exc,
    output logic [ADDR_W-1:0] out_badvaddr
);

    localparam logic [3:0] OP_NONE = 4'd0,  OP_LB  = 4'd1,  OP_LBU = 4'd2,
                           OP_LH   = 4'd3,  OP_LHU = 4'd4,  OP_LW  = 4'd5,
                           OP_SB   = 4'd6,  OP_SH  = 4'd7,  OP_SW  = 4'd8,
                           OP_LWL  = 4'd9,  OP_LWR = 4'd10, OP_SWL = 4'd11,
                           OP_SWR  = 4'd12;
    localparam logic [1:0] MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2;
    localparam logic [5:0] EXC_ADEL = 6'b100100, EXC_ADES = 6'b100101;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;
    state_t state_reg, state_next;

    // Decoded view of the incoming instruction
    logic [3:0]        op_eff;
    logic              dec_load, dec_store, dec_byte, dec_half, dec_word, dec_unal;
    logic              misaligned, dec_go_req;
    logic [ADDR_W-1:0] addr_eff, req_addr, badv_calc;
    logic [1:0]        req_size, k_in;
    logic [3:0]        req_strobe;
    logic [31:0]       req_data;
    logic [5:0]        exc_calc;
    logic [4:0]        sh_lo, sh_hi;

    // Held instruction
    logic [3:0]        op_reg;
    logic [1:0]        k_reg;
    logic [31:0]       rt_reg, val_reg;
    logic [ADDR_W-1:0] pc_reg, badv_reg, dreq_addr_reg;
    logic [4:0]        dst_reg;
    logic              wen_reg;
    logic [5:0]        exc_reg;
    logic [1:0]        dreq_size_reg;
    logic [3:0]        dreq_strobe_reg;
    logic [31:0]       dreq_data_reg;

    // Load extraction
    logic [4:0]        ld_sh_lo, ld_sh_hi;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_val;
    logic              load_op;

    logic accept, capture;

    // Decode incoming op: exception, bus address/size, store strobe and data
    always_comb begin
        op_eff = in_op;
        if (in_op > OP_SWR || (!UNALIGNED_EN && in_op >= OP_LWL))
            op_eff = OP_NONE;
        dec_byte  = op_eff inside {OP_LB, OP_LBU, OP_SB};
        dec_half  = op_eff inside {OP_LH, OP_LHU, OP_SH};
        dec_word  = op_eff inside {OP_LW, OP_SW};
        dec_unal  = op_eff inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR};
        dec_load  = op_eff inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
        dec_store = op_eff inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};

        // Without the alignment check, misaligned addresses are silently truncated
        addr_eff = in_addr;
        if (!ALIGN_CHECK) begin
            if (dec_half) addr_eff[0] = 1'b0;
            if (dec_word) addr_eff[1:0] = 2'b00;
        end
        misaligned = ALIGN_CHECK &&
                     ((dec_half && in_addr[0]) || (dec_word && in_addr[1:0] != 2'b00));

        exc_calc  = 6'd0;
        badv_calc = '0;
        if (in_exc[5]) begin
            exc_calc  = in_exc;
            badv_calc = in_pc;
        end else if (misaligned) begin
            exc_calc  = dec_load ? EXC_ADEL : EXC_ADES;
            badv_calc = in_addr;
        end
        dec_go_req = (dec_load || dec_store) && !exc_calc[5];

        k_in     = addr_eff[1:0];
        sh_lo    = {k_in, 3'b000};
        sh_hi    = {2'd3 - k_in, 3'b000};
        req_addr = dec_unal ? {addr_eff[ADDR_W-1:2], 2'b00} : addr_eff;
        req_size = dec_byte ? MSIZE1 : (dec_half ? MSIZE2 : MSIZE4);

        req_strobe = 4'b0000;
        req_data   = 32'd0;
        case (op_eff)
            OP_SB:   begin req_strobe = 4'b0001 << k_in; req_data = {4{in_rt[7:0]}}; end
            OP_SH:   begin req_strobe = k_in[1] ? 4'b1100 : 4'b0011; req_data = {2{in_rt[15:0]}}; end
            OP_SW:   begin req_strobe = 4'b1111; req_data = in_rt; end
            OP_SWL:  begin req_strobe = 4'b1111 >> (2'd3 - k_in); req_data = in_rt >> sh_hi; end
            OP_SWR:  begin req_strobe = 4'b1111 << k_in; req_data = in_rt << sh_lo; end
            default: ;
        endcase
    end

    // Extract/merge the returned bus word for the held load
    always_comb begin
        ld_sh_lo = {k_reg, 3'b000};
        ld_sh_hi = {2'd3 - k_reg, 3'b000};
        ld_byte  = dresp_data[ld_sh_lo +: 8];
        ld_half  = k_reg[1] ? dresp_data[31:16] : dresp_data[15:0];
        load_val = dresp_data;
        load_op  = 1'b1;
        case (op_reg)
            OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_val = {24'd0, ld_byte};
            OP_LH:   load_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_val = {16'd0, ld_half};
            OP_LW:   load_val = dresp_data;
            OP_LWL:  load_val = (dresp_data << ld_sh_hi) | (rt_reg & ~(32'hFFFF_FFFF << ld_sh_hi));
            OP_LWR:  load_val = (dresp_data >> ld_sh_lo) | (rt_reg & ~(32'hFFFF_FFFF >> ld_sh_lo));
            default: load_op = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        dreq_valid = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = dec_go_req ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                dreq_valid = 1'b1;
                if (flush) begin
                    // Only an accepted request with data still pending needs draining
                    state_next = (dresp_addr_ok && !dresp_data_ok) ? S_DRAIN : S_IDLE;
                end else if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        state_next = S_DONE;
                        capture    = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_next = dresp_data_ok ? S_IDLE : S_DRAIN;
                end else if (dresp_data_ok) begin
                    state_next = S_DONE;
                    capture    = 1'b1;
                end
            end
            S_DONE: begin
                out_valid = !flush;
                in_ready  = out_ready;
                // A flush also kills whatever the upstream stage offers this cycle
                if (flush) begin
                    state_next = S_IDLE;
                end else if (out_ready) begin
                    if (in_valid) begin
                        accept     = 1'b1;
                        state_next = dec_go_req ? S_REQ : S_DONE;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (dresp_data_ok) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Instruction holding registers; request fields are frozen at accept
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg          <= OP_NONE;
            k_reg           <= 2'd0;
            rt_reg          <= 32'd0;
            val_reg         <= 32'd0;
            pc_reg          <= '0;
            badv_reg        <= '0;
            dst_reg         <= 5'd0;
            wen_reg         <= 1'b0;
            exc_reg         <= 6'd0;
            dreq_addr_reg   <= '0;
            dreq_size_reg   <= 2'd0;
            dreq_strobe_reg <= 4'd0;
            dreq_data_reg   <= 32'd0;
        end else if (accept) begin
            op_reg          <= op_eff;
            k_reg           <= k_in;
            rt_reg          <= in_rt;
            val_reg         <= in_val;
            pc_reg          <= in_pc;
            badv_reg        <= badv_calc;
            dst_reg         <= in_dst;
            wen_reg         <= in_wen && !exc_calc[5];
            exc_reg         <= exc_calc;
            dreq_addr_reg   <= req_addr;
            dreq_size_reg   <= req_size;
            dreq_strobe_reg <= req_strobe;
            dreq_data_reg   <= req_data;
        end else if (capture && load_op) begin
            val_reg <= load_val;
        end
    end

    assign dreq_addr    = dreq_addr_reg;
    assign dreq_size    = dreq_size_reg;
    assign dreq_strobe  = dreq_strobe_reg;
    assign dreq_data    = dreq_data_reg;
    assign out_pc       = pc_reg;
    assign out_dst      = dst_reg;
    assign out_wen      = wen_reg;
    assign out_val      = val_reg;
    assign out_exc      = exc_reg;
    assign out_badvaddr = badv_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases, flush/stall
// scenarios and randomized ops compared against a byte-level reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_wen;
    logic [3:0]  in_op;
    logic [31:0] in_addr, in_rt, in_val, in_pc;
    logic [4:0]  in_dst;
    logic [5:0]  in_exc;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic        out_valid, out_ready, out_wen;
    logic [31:0] out_pc, out_val, out_badvaddr;
    logic [4:0]  out_dst;
    logic [5:0]  out_exc;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_rt(in_rt), .in_val(in_val), .in_pc(in_pc), .in_dst(in_dst),
        .in_wen(in_wen), .in_exc(in_exc),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_dst(out_dst),
        .out_wen(out_wen), .out_val(out_val), .out_exc(out_exc), .out_badvaddr(out_badvaddr)
    );

    // Reference model: works on byte lanes rather than shifts
    task automatic model(input logic [3:0] op, input logic [31:0] addr, rt, ival, pc,
                         input logic [5:0] iexc, input logic wen, input logic [31:0] d,
                         output logic gomem, output logic [5:0] exc, output logic [31:0] badv,
                         output logic ow, output logic chkval, output logic [31:0] oval,
                         output logic [31:0] raddr, output logic [1:0] rsize,
                         output logic [3:0] rstrb, output logic isst, output logic [31:0] rdata);
        int k, nb;
        logic ld, st, un;
        logic [7:0] rb [4];
        logic [7:0] db [4];
        logic [7:0] ob [4];
        logic [7:0] lb [4];
        k = int'(addr[1:0]); nb = 0; ld = 0; st = 0; un = 0;
        case (op)
            4'd1, 4'd2:   begin ld = 1; nb = 1; end
            4'd3, 4'd4:   begin ld = 1; nb = 2; end
            4'd5:         begin ld = 1; nb = 4; end
            4'd6:         begin st = 1; nb = 1; end
            4'd7:         begin st = 1; nb = 2; end
            4'd8:         begin st = 1; nb = 4; end
            4'd9, 4'd10:  begin ld = 1; un = 1; end
            4'd11, 4'd12: begin st = 1; un = 1; end
            default: ;
        endcase
        for (int j = 0; j < 4; j++) begin
            rb[j] = rt[8*j +: 8]; db[j] = d[8*j +: 8]; ob[j] = 8'h00; lb[j] = 8'h00;
        end
        exc = 6'd0; badv = 32'd0;
        if (iexc[5]) begin
            exc = iexc; badv = pc;
        end else if ((nb == 2 && (addr % 2) != 0) || (nb == 4 && (addr % 4) != 0)) begin
            exc = ld ? 6'h24 : 6'h25; badv = addr;
        end
        gomem  = (ld || st) && !exc[5];
        ow     = wen && !exc[5];
        chkval = !exc[5] && !st;
        isst   = st;
        raddr  = un ? addr - 32'(k) : addr;
        rsize  = (un || nb == 4) ? 2'd2 : (nb == 2 ? 2'd1 : 2'd0);
        rstrb  = 4'b0000;
        oval   = ival;
        if (!exc[5]) begin
            case (op)
                4'd1: oval = {{24{db[k][7]}}, db[k]};
                4'd2: oval = {24'd0, db[k]};
                4'd3: oval = {{16{db[k+1][7]}}, db[k+1], db[k]};
                4'd4: oval = {16'd0, db[k+1], db[k]};
                4'd5: oval = d;
                4'd6: for (int j = 0; j < 4; j++) begin rstrb[j] = (j == k); ob[j] = rb[0]; end
                4'd7: for (int j = 0; j < 4; j++) begin rstrb[j] = (j / 2 == k / 2); ob[j] = rb[j % 2]; end
                4'd8: for (int j = 0; j < 4; j++) begin rstrb[j] = 1'b1; ob[j] = rb[j]; end
                4'd9: begin
                    for (int j = 0; j < 4; j++) lb[j] = (j >= 3 - k) ? db[j - (3 - k)] : rb[j];
                    oval = {lb[3], lb[2], lb[1], lb[0]};
                end
                4'd10: begin
                    for (int j = 0; j < 4; j++) lb[j] = (j < 4 - k) ? db[j + k] : rb[j];
                    oval = {lb[3], lb[2], lb[1], lb[0]};
                end
                4'd11: for (int j = 0; j <= k; j++) begin rstrb[j] = 1'b1; ob[j] = rb[j + 3 - k]; end
                4'd12: for (int j = k; j < 4; j++) begin rstrb[j] = 1'b1; ob[j] = rb[j - k]; end
                default: ;
            endcase
        end
        rdata = {ob[3], ob[2], ob[1], ob[0]};
    endtask

    // One instruction end to end with a scripted bus; out_ready held high
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, rt, ival,
                          input logic [5:0] iexc, input logic wen, input logic [31:0] d,
                          input int alat, input int dlat);
        logic gomem, ow, chkval, isst;
        logic [5:0] exc;
        logic [31:0] badv, oval, raddr, rdata, pc, sv_addr, sv_data;
        logic [1:0] rsize, sv_size;
        logic [3:0] rstrb, sv_strb;
        logic [4:0] dst;
        int acc_c, data_c, exp_c;
        bit data_done, seen_out, req_seen;
        pc = $urandom; dst = 5'($urandom);
        model(op, addr, rt, ival, pc, iexc, wen, d, gomem, exc, badv, ow, chkval, oval,
              raddr, rsize, rstrb, isst, rdata);
        in_valid = 1; in_op = op; in_addr = addr; in_rt = rt; in_val = ival;
        in_pc = pc; in_dst = dst; in_wen = wen; in_exc = iexc; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        acc_c = -1; data_c = -1; data_done = 0; seen_out = 0; req_seen = 0;
        sv_addr = 0; sv_data = 0; sv_size = 0; sv_strb = 0;
        for (int c = 1; c <= 60; c++) begin
            dresp_addr_ok = 0; dresp_data_ok = 0;
            if (dreq_valid && acc_c < 0 && c >= 1 + alat) begin dresp_addr_ok = 1; acc_c = c; end
            if (acc_c >= 0 && !data_done && c >= acc_c + dlat) begin
                dresp_data_ok = 1; dresp_data = d; data_done = 1; data_c = c;
            end
            @(negedge clk);
            if (dreq_valid) begin
                chk_cnt++;
                if (!gomem) begin
                    $display("FAIL unexpected_req op=%0d addr=%h: dreq_valid=1 required 0", op, addr);
                end else if (!req_seen) begin
                    if ({dreq_addr, dreq_size, dreq_strobe} !== {raddr, rsize, rstrb} ||
                        (isst && dreq_data !== rdata))
                        $display("FAIL req_fields op=%0d: got addr=%h size=%0d strb=%b data=%h required addr=%h size=%0d strb=%b data=%h",
                                 op, dreq_addr, dreq_size, dreq_strobe, dreq_data, raddr, rsize, rstrb, rdata);
                    else pass_cnt++;
                    req_seen = 1;
                    sv_addr = dreq_addr; sv_size = dreq_size; sv_strb = dreq_strobe; sv_data = dreq_data;
                end else begin
                    if ({dreq_addr, dreq_size, dreq_strobe, dreq_data} !== {sv_addr, sv_size, sv_strb, sv_data})
                        $display("FAIL req_stable op=%0d: got addr=%h data=%h required addr=%h data=%h",
                                 op, dreq_addr, dreq_data, sv_addr, sv_data);
                    else pass_cnt++;
                end
            end
            if (out_valid) begin
                seen_out = 1;
                exp_c = gomem ? data_c + 1 : 1;
                chk_cnt++;
                if (c != exp_c) $display("FAIL latency op=%0d: got %0d required %0d", op, c, exp_c);
                else pass_cnt++;
                chk_cnt++;
                if ({out_exc, out_wen} !== {exc, ow})
                    $display("FAIL exc_wen op=%0d addr=%h: got exc=%h wen=%b required exc=%h wen=%b",
                             op, addr, out_exc, out_wen, exc, ow);
                else pass_cnt++;
                chk_cnt++;
                if ({out_pc, out_dst} !== {pc, dst})
                    $display("FAIL pc_dst: got %h/%0d required %h/%0d", out_pc, out_dst, pc, dst);
                else pass_cnt++;
                if (chkval) begin
                    chk_cnt++;
                    if (out_val !== oval)
                        $display("FAIL out_val op=%0d addr=%h rt=%h d=%h: got %h required %h",
                                 op, addr, rt, d, out_val, oval);
                    else pass_cnt++;
                end
                if (exc[5]) begin
                    chk_cnt++;
                    if (out_badvaddr !== badv)
                        $display("FAIL badvaddr op=%0d: got %h required %h", op, out_badvaddr, badv);
                    else pass_cnt++;
                end
                $display("txn op=%0d addr=%h rt=%h d=%h -> val=%h exc=%h wen=%b lat=%0d",
                         op, addr, rt, d, out_val, out_exc, out_wen, c);
            end
            @(posedge clk); #1;
            dresp_addr_ok = 0; dresp_data_ok = 0;
            if (seen_out) break;
        end
        if (!seen_out) begin
            chk_cnt++;
            $display("FAIL timeout op=%0d addr=%h: out_valid=0 required 1 within 60 cycles", op, addr);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data} !== '0)
            $display("FAIL reset_dreq: got %b/%h/%0d/%b/%h required all 0",
                     dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data);
        else pass_cnt++;
        chk_cnt++;
        if ({out_valid, out_pc, out_dst, out_wen, out_val, out_exc, out_badvaddr} !== '0)
            $display("FAIL reset_out: got valid=%b val=%h exc=%h badv=%h required all 0",
                     out_valid, out_val, out_exc, out_badvaddr);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else pass_cnt++;
        // Reset while a request is pending aborts it immediately
        @(posedge clk); #1;
        in_valid = 1; in_op = 4'd5; in_addr = 32'h100; in_exc = 0;
        @(posedge clk); #1;
        in_valid = 0; reset = 1;
        @(negedge clk);
        chk_cnt++;
        if (dreq_valid !== 1'b1) $display("FAIL reset_pre_req: got %b required 1", dreq_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk_cnt++;
        if ({dreq_valid, in_ready, out_valid} !== 3'b010)
            $display("FAIL reset_abort: got dreq/in_ready/out=%b required 010", {dreq_valid, in_ready, out_valid});
        else pass_cnt++;
        $display("txn reset abort done");
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(4'd5,  32'h1004, 32'h0,        32'h0, 6'h00, 1, 32'hDEADBEEF, 0, 0);
        run_op(4'd1,  32'h1003, 32'h0,        32'h0, 6'h00, 1, 32'h80FF0000, 0, 0);
        run_op(4'd2,  32'h1003, 32'h0,        32'h0, 6'h00, 1, 32'h80FF0000, 1, 2);
        run_op(4'd7,  32'h1002, 32'h1234,     32'h0, 6'h00, 0, 32'h0,        0, 1);
        run_op(4'd9,  32'h2001, 32'hAABBCCDD, 32'h0, 6'h00, 1, 32'h44332211, 2, 0);
        run_op(4'd10, 32'h2001, 32'hAABBCCDD, 32'h0, 6'h00, 1, 32'h44332211, 0, 0);
        run_op(4'd12, 32'h2002, 32'h11223344, 32'h0, 6'h00, 0, 32'h0,        0, 0);
        run_op(4'd11, 32'h2001, 32'h11223344, 32'h0, 6'h00, 0, 32'h0,        1, 1);
        run_op(4'd3,  32'h0003, 32'h0,        32'h0, 6'h00, 1, 32'h0,        0, 0);
        run_op(4'd8,  32'h0006, 32'h5,        32'h0, 6'h00, 0, 32'h0,        0, 0);
        run_op(4'd5,  32'h0008, 32'h0,        32'h0, 6'h2A, 1, 32'h0,        0, 0);
        run_op(4'd0,  32'h0001, 32'h0, 32'hCAFEF00D, 6'h00, 1, 32'h0,        0, 0);
    endtask

    task automatic test_flush_req();
        in_valid = 1; in_op = 4'd5; in_addr = 32'h40; in_exc = 0; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0; flush = 1;
        @(negedge clk);
        chk_cnt++;
        if (dreq_valid !== 1'b1) $display("FAIL flush_req_pre: got %b required 1", dreq_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        chk_cnt++;
        if ({dreq_valid, in_ready, out_valid} !== 3'b010)
            $display("FAIL flush_req: got dreq/in_ready/out=%b required 010", {dreq_valid, in_ready, out_valid});
        else pass_cnt++;
        $display("txn flush in REQ");
        @(posedge clk); #1;
    endtask

    task automatic test_flush_wait();
        in_valid = 1; in_op = 4'd5; in_addr = 32'h80; in_exc = 0; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0; dresp_addr_ok = 1;
        @(posedge clk); #1;
        dresp_addr_ok = 0; flush = 1;
        @(negedge clk);
        chk_cnt++;
        if (dreq_valid !== 1'b0) $display("FAIL wait_dreq: got %b required 0", dreq_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        chk_cnt++;
        if ({in_ready, out_valid} !== 2'b00)
            $display("FAIL drain_hold: got in_ready/out=%b required 00", {in_ready, out_valid});
        else pass_cnt++;
        @(posedge clk); #1;
        dresp_data_ok = 1; dresp_data = 32'h12345678;
        @(negedge clk);
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL drain_data: got out_valid=%b required 0", out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        dresp_data_ok = 0;
        @(negedge clk);
        chk_cnt++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL drain_exit: got in_ready/out=%b required 10", {in_ready, out_valid});
        else pass_cnt++;
        $display("txn flush in WAIT, response drained");
        @(posedge clk); #1;
        run_op(4'd5, 32'h84, 32'h0, 32'h0, 6'h00, 1, 32'h0BADF00D, 1, 1);
    endtask

    task automatic test_stall();
        out_ready = 0;
        in_valid = 1; in_op = 4'd0; in_val = 32'h11111111; in_pc = 32'h500; in_exc = 0; in_wen = 1;
        @(posedge clk); #1;
        in_val = 32'h22222222; in_pc = 32'h504;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk_cnt++;
            if ({out_valid, in_ready, out_val, out_pc} !== {2'b10, 32'h11111111, 32'h500})
                $display("FAIL stall_hold cyc=%0d: got valid=%b in_ready=%b val=%h pc=%h required 1 0 11111111 500",
                         i, out_valid, in_ready, out_val, out_pc);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(negedge clk);
        chk_cnt++;
        if ({in_ready, out_val} !== {1'b1, 32'h11111111})
            $display("FAIL stall_release: got in_ready=%b val=%h required 1 11111111", in_ready, out_val);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk_cnt++;
        if ({out_valid, out_val} !== {1'b1, 32'h22222222})
            $display("FAIL stall_next: got valid=%b val=%h required 1 22222222", out_valid, out_val);
        else pass_cnt++;
        $display("txn stall 3 cycles then release");
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [6];
        for (int i = 0; i < 6; i++) vals[i] = $urandom;
        out_ready = 1; in_op = 4'd0; in_exc = 0; in_wen = 1;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin in_valid = 1; in_val = vals[i]; end
            else in_valid = 0;
            @(negedge clk);
            if (i >= 1) begin
                chk_cnt++;
                if ({out_valid, out_val} !== {1'b1, vals[i-1]})
                    $display("FAIL b2b idx=%0d: got valid=%b val=%h required 1 %h", i - 1, out_valid, out_val, vals[i-1]);
                else pass_cnt++;
                $display("txn b2b idx=%0d val=%h", i - 1, out_val);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [5:0] e;
        for (int n = 0; n < 80; n++) begin
            a = $urandom;
            e = ($urandom_range(0, 7) == 0) ? {1'b1, 5'($urandom)} : 6'd0;
            run_op(4'($urandom_range(0, 15)), a, $urandom, $urandom, e, 1'($urandom),
                   $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_op = 0; in_addr = 0; in_rt = 0; in_val = 0;
        in_pc = 0; in_dst = 0; in_wen = 0; in_exc = 0; dresp_addr_ok = 0; dresp_data_ok = 0;
        dresp_data = 0; out_ready = 1;
        test_reset();
        test_directed();
        test_flush_req();
        test_flush_wait();
        test_stall();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
